// File: rtl/miner_hash_sequencer.sv
// Control sequencer for double SHA-256: MSA/COMP/ADD enables over NUM_BLOCKS blocks plus one final pass.
// Latency: msa_en one cycle after hash_start; done (NUM_BLOCKS+1)*(MSA_CYCLES+COMP_CYCLES+1)+1 cycles after it.
// Backpressure: hold freezes state/counter and masks enables; abort > hash_start > hold.
module miner_hash_sequencer #(
    parameter int NUM_BLOCKS  = 2,
    parameter int MSA_CYCLES  = 48,
    parameter int COMP_CYCLES = 64,
    localparam int BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
    localparam int MAX_C = (MSA_CYCLES > COMP_CYCLES) ? MSA_CYCLES : COMP_CYCLES,
    localparam int CNT_W = $clog2(MAX_C + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             hash_start,
    input  logic             abort,
    input  logic             hold,
    output logic [BLK_W-1:0] blk_idx,
    output logic             pass2,
    output logic             msa_en,
    output logic             comp_en,
    output logic             add_en,
    output logic             msa2_en,
    output logic             comp2_en,
    output logic             add2_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MSA  = 3'd1,
        S_COMP = 3'd2,
        S_ADD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MSA_LAST  = CNT_W'(MSA_CYCLES - 1);
    localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(COMP_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(NUM_BLOCKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             pass2_q, pass2_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        pass2_d = pass2_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            blk_d   = '0;
            pass2_d = 1'b0;
        end else if (hash_start) begin
            state_d = S_MSA;
            cnt_d   = '0;
            blk_d   = '0;
            pass2_d = 1'b0;
        end else begin
            case (state_q)
                S_MSA: if (!hold) begin
                    if (cnt_q == MSA_LAST) begin
                        state_d = S_COMP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_COMP: if (!hold) begin
                    if (cnt_q == COMP_LAST) begin
                        state_d = S_ADD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ADD: if (!hold) begin
                    cnt_d = '0;
                    if (pass2_q) begin
                        state_d = S_DONE;
                    end else if (blk_q == BLK_LAST) begin
                        state_d = S_MSA;
                        pass2_d = 1'b1;
                        blk_d   = '0;
                    end else begin
                        state_d = S_MSA;
                        blk_d   = blk_q + BLK_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    blk_d   = '0;
                    pass2_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            pass2_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            pass2_q <= pass2_d;
            busy_q  <= busy_d;
        end
    end

    // Pulses are qualified by this cycle's controls so a stalled or cancelled phase never kicks the datapath.
    logic go;
    logic first_cyc;
    assign go        = !abort && !hash_start && !hold;
    assign first_cyc = (cnt_q == '0) && go;

    assign msa_en   = (state_q == S_MSA)  && first_cyc && !pass2_q;
    assign msa2_en  = (state_q == S_MSA)  && first_cyc &&  pass2_q;
    assign comp_en  = (state_q == S_COMP) && first_cyc && !pass2_q;
    assign comp2_en = (state_q == S_COMP) && first_cyc &&  pass2_q;
    assign add_en   = (state_q == S_ADD)  && go && !pass2_q;
    assign add2_en  = (state_q == S_ADD)  && go &&  pass2_q;
    assign done     = (state_q == S_DONE) && !abort && !hash_start;

    assign blk_idx = blk_q;
    assign pass2   = pass2_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_miner_hash_sequencer.sv
// Directed bench: default-parameter sequencer plus a small (3,4,5) instance, pulse cycles logged per run.
module tb_miner_hash_sequencer;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic hash_start = 1'b0;
    logic abort = 1'b0;
    logic hold = 1'b0;

    logic       a_blk;
    logic [1:0] b_blk;
    logic a_pass2, a_msa, a_comp, a_add, a_msa2, a_comp2, a_add2, a_busy, a_done;
    logic b_pass2, b_msa, b_comp, b_add, b_msa2, b_comp2, b_add2, b_busy, b_done;

    always #5 clk = ~clk;

    miner_hash_sequencer u_a (
        .clk(clk), .n_rst(n_rst), .hash_start(hash_start), .abort(abort), .hold(hold),
        .blk_idx(a_blk), .pass2(a_pass2), .msa_en(a_msa), .comp_en(a_comp), .add_en(a_add),
        .msa2_en(a_msa2), .comp2_en(a_comp2), .add2_en(a_add2), .busy(a_busy), .done(a_done)
    );

    miner_hash_sequencer #(.NUM_BLOCKS(3), .MSA_CYCLES(4), .COMP_CYCLES(5)) u_b (
        .clk(clk), .n_rst(n_rst), .hash_start(hash_start), .abort(abort), .hold(hold),
        .blk_idx(b_blk), .pass2(b_pass2), .msa_en(b_msa), .comp_en(b_comp), .add_en(b_add),
        .msa2_en(b_msa2), .comp2_en(b_comp2), .add2_en(b_add2), .busy(b_busy), .done(b_done)
    );

    logic sel = 1'b0;
    logic [1:0] o_blk;
    logic o_pass2, o_msa, o_comp, o_add, o_msa2, o_comp2, o_add2, o_busy, o_done;
    assign o_blk   = sel ? b_blk   : {1'b0, a_blk};
    assign o_pass2 = sel ? b_pass2 : a_pass2;
    assign o_msa   = sel ? b_msa   : a_msa;
    assign o_comp  = sel ? b_comp  : a_comp;
    assign o_add   = sel ? b_add   : a_add;
    assign o_msa2  = sel ? b_msa2  : a_msa2;
    assign o_comp2 = sel ? b_comp2 : a_comp2;
    assign o_add2  = sel ? b_add2  : a_add2;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int msa_q[$], comp_q[$], add_q[$], msa2_q[$], comp2_q[$], add2_q[$], done_q[$], blk_q[$];
    int pass2_at[$];
    int busy_n, busy_first, busy_last, multi, snap_k;
    logic [10:0] snap;

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [10:0] outs();
        return {o_busy, o_pass2, o_blk, o_msa, o_comp, o_add, o_msa2, o_comp2, o_add2, o_done};
    endfunction

    task automatic do_reset();
        n_rst = 1'b0;
        hash_start = 1'b0;
        abort = 1'b0;
        hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Cycle k's inputs are applied 1 after edge k-1 and sampled by edge k; outputs are read 2 after edge k-1.
    task automatic run(input int n, input int h0, input int h1, input int ab, input int rs);
        msa_q.delete(); comp_q.delete(); add_q.delete(); msa2_q.delete();
        comp2_q.delete(); add2_q.delete(); done_q.delete(); blk_q.delete(); pass2_at.delete();
        busy_n = 0; busy_first = -1; busy_last = -1; multi = 0; snap = '0;
        do_reset();
        for (int k = 0; k <= n; k++) begin
            hash_start = (k == 0) || (k == rs);
            hold       = (k >= h0) && (k < h1);
            abort      = (k == ab);
            #1;
            if (o_msa)   msa_q.push_back(k);
            if (o_comp)  comp_q.push_back(k);
            if (o_add)   begin add_q.push_back(k); blk_q.push_back(int'(o_blk)); end
            if (o_msa2)  msa2_q.push_back(k);
            if (o_comp2) comp2_q.push_back(k);
            if (o_add2)  add2_q.push_back(k);
            if (o_done)  done_q.push_back(k);
            if (o_pass2) pass2_at.push_back(k);
            if ((int'(o_msa) + int'(o_comp) + int'(o_add) + int'(o_msa2) + int'(o_comp2) + int'(o_add2)) > 1)
                multi++;
            if (o_busy) begin
                busy_n++;
                busy_last = k;
                if (busy_first < 0) busy_first = k;
            end
            if (k == snap_k) snap = outs();
            @(posedge clk);
            #1;
        end
        hash_start = 1'b0;
        hold = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        #2;
        check("reset_outs_a", int'(outs()), 0);
        sel = 1'b1;
        #1;
        check("reset_outs_b", int'(outs()), 0);
        sel = 1'b0;

        // 1: nominal hash
        snap_k = -1;
        run(345, -1, -1, -1, -1);
        check("t1_msa0", qat(msa_q, 0), 1);
        check("t1_msa1", qat(msa_q, 1), 114);
        check("t1_msa_n", msa_q.size(), 2);
        check("t1_comp0", qat(comp_q, 0), 49);
        check("t1_comp1", qat(comp_q, 1), 162);
        check("t1_add0", qat(add_q, 0), 113);
        check("t1_add1", qat(add_q, 1), 226);
        check("t1_blk_add0", qat(blk_q, 0), 0);
        check("t1_blk_add1", qat(blk_q, 1), 1);
        check("t1_msa2", qat(msa2_q, 0), 227);
        check("t1_comp2", qat(comp2_q, 0), 275);
        check("t1_add2", qat(add2_q, 0), 339);
        check("t1_done", qat(done_q, 0), 340);
        check("t1_done_n", done_q.size(), 1);
        check("t1_busy_first", busy_first, 1);
        check("t1_busy_last", busy_last, 340);
        check("t1_busy_n", busy_n, 340);
        check("t1_multi", multi, 0);

        // 2: 5-cycle stall at block-0 COMP cnt==10 (cycle 59)
        run(350, 59, 64, -1, -1);
        check("t2_comp0", qat(comp_q, 0), 49);
        check("t2_comp_n", comp_q.size(), 2);
        check("t2_add0", qat(add_q, 0), 118);
        check("t2_msa1", qat(msa_q, 1), 119);
        check("t2_comp1", qat(comp_q, 1), 167);
        check("t2_msa2", qat(msa2_q, 0), 232);
        check("t2_add2", qat(add2_q, 0), 344);
        check("t2_done", qat(done_q, 0), 345);
        check("t2_multi", multi, 0);

        // 3: stall exactly on the due comp_en cycle
        run(350, 49, 52, -1, -1);
        check("t3_comp0", qat(comp_q, 0), 52);
        check("t3_comp_n", comp_q.size(), 2);
        check("t3_add0", qat(add_q, 0), 116);
        check("t3_done", qat(done_q, 0), 343);

        // 4: abort during final-pass COMP
        snap_k = 301;
        run(345, -1, -1, 300, -1);
        check("t4_comp2", qat(comp2_q, 0), 275);
        check("t4_busy_last", busy_last, 300);
        check("t4_outs_after", int'(snap), 0);
        check("t4_add2_n", add2_q.size(), 0);
        check("t4_done_n", done_q.size(), 0);

        // 5: restart mid block-1 MSA; outputs {busy,pass2,blk,msa,...} at cycle 131 = busy|msa_en
        snap_k = 131;
        run(475, -1, -1, -1, 130);
        check("t5_snap", int'(snap), 11'b100_0100_0000);
        check("t5_msa2", qat(msa_q, 2), 131);
        check("t5_msa_n", msa_q.size(), 4);
        check("t5_add2", qat(add2_q, 0), 469);
        check("t5_done", qat(done_q, 0), 470);
        check("t5_done_n", done_q.size(), 1);

        // 6: NUM_BLOCKS=3, MSA_CYCLES=4, COMP_CYCLES=5
        sel = 1'b1;
        snap_k = -1;
        run(45, -1, -1, -1, -1);
        check("t6_msa0", qat(msa_q, 0), 1);
        check("t6_msa2nd", qat(msa_q, 2), 21);
        check("t6_comp0", qat(comp_q, 0), 5);
        check("t6_add2nd", qat(add_q, 2), 30);
        check("t6_blk0", qat(blk_q, 0), 0);
        check("t6_blk1", qat(blk_q, 1), 1);
        check("t6_blk2", qat(blk_q, 2), 2);
        check("t6_pass2_rise", qat(pass2_at, 0), 31);
        check("t6_msa2", qat(msa2_q, 0), 31);
        check("t6_add2", qat(add2_q, 0), 40);
        check("t6_done", qat(done_q, 0), 41);
        check("t6_busy_n", busy_n, 41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
